cflog_write_sched: RTL and testbench

// Sequences all writes into the CFLog memory for the CFA module. Arbitrates between
// two requesters: the branch logger (src/dest pair) and the loop monitor (exit count).

---
 rtl/cflog_write_sched.sv | 134 +++++++++++++
 tb/tb_cflog_write_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cflog_write_sched.sv
// CFLog write scheduler: arbitrates loop-monitor and branch-logger entries and
// writes each one into the log as consecutive 16-bit words.
module cflog_write_sched #(
    parameter int unsigned PTR_W    = 8,
    parameter logic [15:0] LOOP_TAG = 16'hffff
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_req,
    input  logic [15:0]      br_src,
    input  logic [15:0]      br_dest,
    output logic             br_ack,
    input  logic             loop_req,
    input  logic [31:0]      loop_ctr,
    output logic             loop_ack,
    input  logic             flush_done,
    output logic             log_wr_en,
    output logic [PTR_W-1:0] log_addr,
    output logic [15:0]      log_wdata,
    output logic [PTR_W:0]   log_ptr,
    output logic             log_full
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << PTR_W;

    typedef enum logic [2:0] {
        IDLE,
        BR_SRC,
        BR_DST,
        LP_TAG,
        LP_HI,
        LP_LO,
        FULL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] ptr;
    logic [CNT_W-1:0] free_c;
    logic [15:0]      src_q;
    logic [15:0]      dst_q;
    logic [31:0]      ctr_q;

    // Room left for a whole entry; an entry is only accepted if it fits entirely.
    assign free_c  = DEPTH - ptr;
    assign log_ptr = ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            ctr_q     <= '0;
            br_ack    <= 1'b0;
            loop_ack  <= 1'b0;
            log_wr_en <= 1'b0;
            log_addr  <= '0;
            log_wdata <= '0;
            log_full  <= 1'b0;
        end else begin
            br_ack    <= 1'b0;
            loop_ack  <= 1'b0;
            log_wr_en <= 1'b0;
            log_addr  <= '0;
            log_wdata <= '0;

            // Write states each emit one word at the current pointer and advance it.
            if (state == BR_SRC || state == BR_DST || state == LP_TAG ||
                state == LP_HI  || state == LP_LO) begin
                log_wr_en <= 1'b1;
                log_addr  <= ptr[PTR_W-1:0];
                ptr       <= ptr + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    // Loop count goes first so it precedes the branch that exits the loop.
                    if (loop_req) begin
                        if (free_c >= CNT_W'(3)) begin
                            loop_ack <= 1'b1;
                            ctr_q    <= loop_ctr;
                            state    <= LP_TAG;
                        end else begin
                            log_full <= 1'b1;
                            state    <= FULL;
                        end
                    end else if (br_req) begin
                        if (free_c >= CNT_W'(2)) begin
                            br_ack <= 1'b1;
                            src_q  <= br_src;
                            dst_q  <= br_dest;
                            state  <= BR_SRC;
                        end else begin
                            log_full <= 1'b1;
                            state    <= FULL;
                        end
                    end else if (flush_done) begin
                        ptr <= '0;
                    end
                end
                BR_SRC: begin
                    log_wdata <= src_q;
                    state     <= BR_DST;
                end
                BR_DST: begin
                    log_wdata <= dst_q;
                    state     <= IDLE;
                end
                LP_TAG: begin
                    log_wdata <= LOOP_TAG;
                    state     <= LP_HI;
                end
                LP_HI: begin
                    log_wdata <= ctr_q[31:16];
                    state     <= LP_LO;
                end
                LP_LO: begin
                    log_wdata <= ctr_q[15:0];
                    state     <= IDLE;
                end
                FULL: begin
                    if (flush_done) begin
                        ptr      <= '0;
                        log_full <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cflog_write_sched.sv
// Scoreboard bench for cflog_write_sched with an 8-word log (PTR_W=3).
module tb_cflog_write_sched;

    localparam int unsigned PTR_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             br_req;
    logic [15:0]      br_src;
    logic [15:0]      br_dest;
    logic             br_ack;
    logic             loop_req;
    logic [31:0]      loop_ctr;
    logic             loop_ack;
    logic             flush_done;
    logic             log_wr_en;
    logic [PTR_W-1:0] log_addr;
    logic [15:0]      log_wdata;
    logic [PTR_W:0]   log_ptr;
    logic             log_full;

    typedef struct packed {
        logic [PTR_W-1:0] addr;
        logic [15:0]      data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_w;
    int  tests = 0;
    int  fails = 0;
    bit  got;
    bit  seen;
    int  gap;

    cflog_write_sched #(.PTR_W(PTR_W), .LOOP_TAG(16'hffff)) dut (
        .clk(clk), .reset(reset),
        .br_req(br_req), .br_src(br_src), .br_dest(br_dest), .br_ack(br_ack),
        .loop_req(loop_req), .loop_ctr(loop_ctr), .loop_ack(loop_ack),
        .flush_done(flush_done),
        .log_wr_en(log_wr_en), .log_addr(log_addr), .log_wdata(log_wdata),
        .log_ptr(log_ptr), .log_full(log_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [PTR_W-1:0] a, input logic [15:0] d);
        exp_q.push_back(wr_t'{addr: a, data: d});
    endtask

    // Monitor: every log write must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && log_wr_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                         log_addr, log_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("wr_addr", 32'(log_addr), 32'(exp_w.addr));
                check("wr_data", 32'(log_wdata), 32'(exp_w.data));
            end
        end
    end

    task automatic wait_ack(input bit is_loop, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((is_loop && loop_ack) || (!is_loop && br_ack)) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic branch(input logic [15:0] s, input logic [15:0] d, input logic [PTR_W-1:0] a);
        bit h;
        br_src  = s;
        br_dest = d;
        br_req  = 1'b1;
        wait_ack(1'b0, h);
        check("br_ack_seen", 32'(h), 32'd1);
        if (h) begin
            push(a, s);
            push(PTR_W'(a + 1), d);
        end
        br_req = 1'b0;
        @(negedge clk);
        check("br_ack_pulse", 32'(br_ack), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic loop_entry(input logic [31:0] c, input logic [PTR_W-1:0] a);
        bit h;
        loop_ctr = c;
        loop_req = 1'b1;
        wait_ack(1'b1, h);
        check("loop_ack_seen", 32'(h), 32'd1);
        if (h) begin
            push(a, 16'hffff);
            push(PTR_W'(a + 1), c[31:16]);
            push(PTR_W'(a + 2), c[15:0]);
        end
        loop_req = 1'b0;
        @(negedge clk);
        check("loop_ack_pulse", 32'(loop_ack), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic flush();
        flush_done = 1'b1;
        @(negedge clk);
        flush_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; br_req = 1'b0; br_src = '0; br_dest = '0;
        loop_req = 1'b0; loop_ctr = '0; flush_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(log_wr_en), 32'd0);
        check("rst_ptr", 32'(log_ptr), 32'd0);
        check("rst_full", 32'(log_full), 32'd0);
        check("rst_wdata", 32'(log_wdata), 32'd0);
        check("rst_acks", 32'({br_ack, loop_ack}), 32'd0);
        reset = 1'b0;

        // Reset in the middle of a loop entry, while the high count word is due.
        loop_ctr = 32'hcafe0001;
        loop_req = 1'b1;
        wait_ack(1'b1, got);
        check("mid_loop_ack", 32'(got), 32'd1);
        push(PTR_W'(0), 16'hffff);
        loop_req = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_wr_en", 32'(log_wr_en), 32'd0);
        check("mid_rst_ptr", 32'(log_ptr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_rst_pending", 32'(exp_q.size()), 32'd0);
        check("mid_rst_ptr_after", 32'(log_ptr), 32'd0);

        branch(16'he0a2, 16'he0c0, PTR_W'(0));
        check("br_ptr", 32'(log_ptr), 32'd2);
        loop_entry(32'h00012345, PTR_W'(2));
        check("loop_ptr", 32'(log_ptr), 32'd5);
        flush();
        check("idle_flush_ptr", 32'(log_ptr), 32'd0);

        // Simultaneous requests: loop entry first, then the branch after one idle cycle.
        loop_ctr = 32'hdeadbeef; br_src = 16'h1111; br_dest = 16'h2222;
        loop_req = 1'b1; br_req = 1'b1;
        wait_ack(1'b1, got);
        check("sim_loop_first", 32'(got), 32'd1);
        check("sim_no_br_ack", 32'(br_ack), 32'd0);
        push(PTR_W'(0), 16'hffff); push(PTR_W'(1), 16'hdead); push(PTR_W'(2), 16'hbeef);
        loop_req = 1'b0;
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            gap++;
            if (br_ack) break;
        end
        check("sim_br_gap", 32'(gap), 32'd4);
        push(PTR_W'(3), 16'h1111); push(PTR_W'(4), 16'h2222);
        br_req = 1'b0;
        repeat (4) @(negedge clk);
        check("sim_ptr", 32'(log_ptr), 32'd5);

        // Loop entry with only two words free goes to FULL.
        flush();
        branch(16'h0a00, 16'h0a01, PTR_W'(0));
        branch(16'h0b00, 16'h0b01, PTR_W'(2));
        branch(16'h0c00, 16'h0c01, PTR_W'(4));
        loop_ctr = 32'h00000007;
        loop_req = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (loop_ack) seen = 1'b1;
        end
        check("full_no_ack", 32'(seen), 32'd0);
        check("full_flag", 32'(log_full), 32'd1);
        check("full_ptr", 32'(log_ptr), 32'd6);
        flush();
        check("flush_full_clr", 32'(log_full), 32'd0);
        check("flush_ptr", 32'(log_ptr), 32'd0);
        wait_ack(1'b1, got);
        check("after_flush_loop_ack", 32'(got), 32'd1);
        push(PTR_W'(0), 16'hffff); push(PTR_W'(1), 16'h0000); push(PTR_W'(2), 16'h0007);
        loop_req = 1'b0;
        repeat (5) @(negedge clk);
        check("after_flush_ptr", 32'(log_ptr), 32'd3);

        // Branch exactly fills the log; the next one must wait in FULL.
        flush();
        branch(16'h1000, 16'h1001, PTR_W'(0));
        branch(16'h2000, 16'h2001, PTR_W'(2));
        branch(16'h3000, 16'h3001, PTR_W'(4));
        branch(16'h4000, 16'h4001, PTR_W'(6));
        check("boundary_ptr", 32'(log_ptr), 32'd8);
        br_src = 16'h5000; br_dest = 16'h5001;
        br_req = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (br_ack) seen = 1'b1;
        end
        check("boundary_no_ack", 32'(seen), 32'd0);
        check("boundary_full", 32'(log_full), 32'd1);
        check("boundary_ptr_held", 32'(log_ptr), 32'd8);
        flush();
        wait_ack(1'b0, got);
        check("boundary_resume_ack", 32'(got), 32'd1);
        push(PTR_W'(0), 16'h5000); push(PTR_W'(1), 16'h5001);
        br_req = 1'b0;
        repeat (4) @(negedge clk);
        check("boundary_resume_ptr", 32'(log_ptr), 32'd2);
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
